// File: rtl/adder_share_pkg.sv
// -----------------------------------------------------------------------------
// adder_share_pkg
// Shared definitions for the adder-sharing arbiter slice.
//   DATA_W        : operand / result width
//   MAX_REQ       : largest supported requester count
//   IDX_W         : width of a requester index
//   sum_t         : {carry, sum} result of one addition
//   onehot_to_idx : converts a one-hot requester vector to its index
// -----------------------------------------------------------------------------
package adder_share_pkg;

  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef logic [DATA_W:0] sum_t;

  // OR-reduction of the set bit positions; exact for one-hot or zero inputs.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] i_oh);
    logic [IDX_W-1:0] v_idx;
    v_idx = {IDX_W{1'b0}};
    for (int i = 0; i < MAX_REQ; i++) begin
      v_idx = v_idx | ({IDX_W{i_oh[i]}} & IDX_W'(i));
    end
    return v_idx;
  endfunction

endpackage

// File: rtl/adder_share_arb_rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Combinational rotating-priority arbiter. Starting at i_ptr and wrapping
// modulo N, the first eligible requester receives a one-hot grant.
//   i_eligible [N]  : requesters allowed to win this cycle
//   i_ptr      [PW] : scan start position
//   o_grant    [N]  : one-hot grant, or zero when nobody is eligible
// -----------------------------------------------------------------------------
module rr_grant #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  // Scan from the pointer; only the first eligible requester is granted.
  always_comb begin
    logic          v_found;
    logic [PW-1:0] v_sel;
    o_grant = {N{1'b0}};
    v_found = 1'b0;
    v_sel   = {PW{1'b0}};
    for (int off = 0; off < N; off++) begin
      v_sel = PW'((int'(i_ptr) + off) % N);
      if (i_eligible[v_sel] && !v_found) begin
        o_grant[v_sel] = 1'b1;
        v_found        = 1'b1;
      end else begin
        v_found = v_found;
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// -----------------------------------------------------------------------------
// adder_share_arb
// Shares one pipelined 32-bit adder between NUM_REQ requesters (okClk domain).
// Requester 0 is the host path; the others are internal datapath clients.
// Each requester may have one operation in flight; results come back on a
// shared bus tagged one-hot, ADD_LATENCY cycles after acceptance.
//
// Ports:
//   okClk       : clock
//   rst_n       : asynchronous active-low reset
//   req_valid   : per-requester request
//   req_ready   : one-hot grant (combinational); accept = valid & ready
//   req_a/req_b : flat operands, requester i at [32*i+31:32*i]
//   resp_valid  : one-hot, one-cycle result ownership pulse
//   resp_sum    : a+b mod 2^32, held between pulses
//   resp_carry  : carry out of bit 31, held between pulses
//   busy        : any operation in flight
//
// Build option ADDER_SHARE_ARB_HOST_PRIO_EN: requester 0 gets strict priority;
// round-robin covers only requesters 1..NUM_REQ-1 and grants to requester 0
// leave the pointer untouched. Undefined: pure round-robin over everyone.
// -----------------------------------------------------------------------------
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 1
) (
  input  logic                      okClk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_sum,
  output logic                      resp_carry,
  output logic                      busy
);

  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("adder_share_arb: NUM_REQ out of range");
  end
  if (ADD_LATENCY < 1 || ADD_LATENCY > 4) begin : g_bad_latency
    $error("adder_share_arb: ADD_LATENCY out of range");
  end

  // Registers
  logic [NUM_REQ-1:0] r_outstanding;
  logic [PW-1:0]      r_ptr;
  logic               r_busy;
  logic [NUM_REQ-1:0] r_tag [ADD_LATENCY];  // one-hot owner, zero when stage empty
  sum_t               r_sum [ADD_LATENCY];  // held while the stage is empty

  // Wires
  logic [NUM_REQ-1:0] w_resp_tag;
  logic [NUM_REQ-1:0] w_out_eff;
  logic [NUM_REQ-1:0] w_out_nxt;
  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_ptr_en;
  logic [IDX_W-1:0]   w_idx;
  logic [PW-1:0]      w_ptr_nxt;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  sum_t               w_sum;

  assign w_resp_tag = r_tag[ADD_LATENCY-1];

  // A requester whose result is on the bus this cycle counts as free, so it
  // can be granted in the same cycle it receives its response.
  assign w_out_eff  = r_outstanding & ~w_resp_tag;
  assign w_eligible = req_valid & ~w_out_eff;
  assign w_out_nxt  = w_out_eff | w_grant;

`ifdef ADDER_SHARE_ARB_HOST_PRIO_EN
  localparam logic [NUM_REQ-1:0] HOST_BIT = NUM_REQ'(1'b1);

  logic [NUM_REQ-1:0] w_rr_elig;
  logic [NUM_REQ-1:0] w_rr_grant;

  // Host is removed from the rotation and wins outright when eligible.
  assign w_rr_elig = w_eligible & ~HOST_BIT;

  rr_grant #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_grant (
    .i_eligible (w_rr_elig),
    .i_ptr      (r_ptr),
    .o_grant    (w_rr_grant)
  );

  assign w_grant  = w_eligible[0] ? HOST_BIT : w_rr_grant;
  assign w_ptr_en = |(w_grant & ~HOST_BIT);
`else
  rr_grant #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_grant (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant)
  );

  assign w_ptr_en = |w_grant;
`endif

  assign w_idx = onehot_to_idx(MAX_REQ'(w_grant));

  // Pointer moves to the requester after the winner, wrapping at NUM_REQ.
  always_comb begin
    if (int'(w_idx) == NUM_REQ - 1) begin
      w_ptr_nxt = {PW{1'b0}};
    end else begin
      w_ptr_nxt = w_idx[PW-1:0] + PW'(1'b1);
    end
  end

  // Operand select: AND-OR mux on the one-hot grant.
  always_comb begin
    w_a = {DATA_W{1'b0}};
    w_b = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_a = w_a | ({DATA_W{w_grant[i]}} & req_a[i*DATA_W +: DATA_W]);
      w_b = w_b | ({DATA_W{w_grant[i]}} & req_b[i*DATA_W +: DATA_W]);
    end
  end

  assign w_sum = {1'b0, w_a} + {1'b0, w_b};

  // Outstanding flags, round-robin pointer and busy flag.
  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= {NUM_REQ{1'b0}};
      r_ptr         <= {PW{1'b0}};
      r_busy        <= 1'b0;
    end else begin
      r_outstanding <= w_out_nxt;
      r_busy        <= |w_out_nxt;
      if (w_ptr_en) begin
        r_ptr <= w_ptr_nxt;
      end else begin
        r_ptr <= r_ptr;
      end
    end
  end

  // Adder pipeline: stage 0 captures the accepted sum, later stages shift.
  // Sums only move with a valid tag so the last stage holds the previous result.
  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < ADD_LATENCY; s++) begin
        r_tag[s] <= {NUM_REQ{1'b0}};
        r_sum[s] <= {(DATA_W+1){1'b0}};
      end
    end else begin
      r_tag[0] <= w_grant;
      if (|w_grant) begin
        r_sum[0] <= w_sum;
      end else begin
        r_sum[0] <= r_sum[0];
      end
      for (int s = 1; s < ADD_LATENCY; s++) begin
        r_tag[s] <= r_tag[s-1];
        if (|r_tag[s-1]) begin
          r_sum[s] <= r_sum[s-1];
        end else begin
          r_sum[s] <= r_sum[s];
        end
      end
    end
  end

  assign req_ready  = w_grant;
  assign resp_valid = w_resp_tag;
  assign resp_sum   = r_sum[ADD_LATENCY-1][DATA_W-1:0];
  assign resp_carry = r_sum[ADD_LATENCY-1][DATA_W];
  assign busy       = r_busy;

endmodule

// File: tb/tb_adder_share_arb.sv
module tb_adder_share_arb;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [N-1:0]    v1, ready1, rv1, v3, ready3, rv3;
  logic [N*32-1:0] a1, b1, a3, b3;
  logic [31:0]     sum1, sum3;
  logic            carry1, carry3, busy1, busy3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [N-1:0] tag;
    logic [31:0]  sum;
    logic         carry;
    int           at;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  adder_share_arb #(.NUM_REQ(N), .ADD_LATENCY(1)) dut1 (
    .okClk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(ready1),
    .req_a(a1), .req_b(b1), .resp_valid(rv1), .resp_sum(sum1),
    .resp_carry(carry1), .busy(busy1)
  );

  adder_share_arb #(.NUM_REQ(N), .ADD_LATENCY(3)) dut3 (
    .okClk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(ready3),
    .req_a(a3), .req_b(b3), .resp_valid(rv3), .resp_sum(sum3),
    .resp_carry(carry3), .busy(busy3)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [N-1:0] g, input logic [N*32-1:0] a,
                                  input logic [N*32-1:0] b, input int at);
    exp_t        e;
    logic [32:0] s;
    int          idx;
    idx = 0;
    for (int i = 0; i < N; i++) if (g[i]) idx = i;
    s       = {1'b0, a[idx*32 +: 32]} + {1'b0, b[idx*32 +: 32]};
    e.tag   = g;
    e.sum   = s[31:0];
    e.carry = s[32];
    e.at    = at;
    return e;
  endfunction

  // One clock: check grants mid-cycle, log expected responses, return #1 after the edge.
  task automatic step(input logic [N-1:0] e1, input logic [N-1:0] e3);
    @(negedge clk);
    chk("ready1", 64'(ready1), 64'(e1));
    chk("ready3", 64'(ready3), 64'(e3));
    if (e1 != 4'd0) q1.push_back(mk_exp(e1, a1, b1, cyc + 1));
    if (e3 != 4'd0) q3.push_back(mk_exp(e3, a3, b3, cyc + 3));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 4'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q1.delete();
    q3.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Scoreboard monitor for the latency-1 instance.
  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].at < cyc) begin
      exp_t m;
      m = q1.pop_front();
      checks++; errors++;
      $display("FAIL resp1_missing actual=none expected_tag=%0h", m.tag);
    end
    if (rv1 != 4'd0) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp1_unexpected actual=%0h expected=none", rv1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("resp1_tag",   64'(rv1),    64'(e.tag));
        chk("resp1_sum",   64'(sum1),   64'(e.sum));
        chk("resp1_carry", 64'(carry1), 64'(e.carry));
        chk("resp1_cycle", 64'(cyc),    64'(e.at));
      end
    end
  end

  // Scoreboard monitor for the latency-3 instance.
  always @(negedge clk) begin
    if (q3.size() > 0 && q3[0].at < cyc) begin
      exp_t m;
      m = q3.pop_front();
      checks++; errors++;
      $display("FAIL resp3_missing actual=none expected_tag=%0h", m.tag);
    end
    if (rv3 != 4'd0) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp3_unexpected actual=%0h expected=none", rv3);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("resp3_tag",   64'(rv3),    64'(e.tag));
        chk("resp3_sum",   64'(sum3),   64'(e.sum));
        chk("resp3_carry", 64'(carry3), 64'(e.carry));
        chk("resp3_cycle", 64'(cyc),    64'(e.at));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    v1 = 4'd0; a1 = '0; b1 = '0;
    v3 = 4'd0; a3 = '0; b3 = '0;
    do_reset();

    // Reset state
    chk("rst_resp_valid1", 64'(rv1),    64'd0);
    chk("rst_sum1",        64'(sum1),   64'd0);
    chk("rst_carry1",      64'(carry1), 64'd0);
    chk("rst_busy1",       64'(busy1),  64'd0);
    chk("rst_resp_valid3", 64'(rv3),    64'd0);
    chk("rst_busy3",       64'(busy3),  64'd0);

    // Host request 5 + 7
    v1 = 4'b0001; a1[31:0] = 32'h5; b1[31:0] = 32'h7;
    step(4'b0001, 4'd0);
    v1 = 4'd0;
    chk("busy1_inflight", 64'(busy1), 64'd1);
    step(4'd0, 4'd0);
    chk("hold_sum_c",   64'(sum1),   64'hC);
    chk("hold_carry_c", 64'(carry1), 64'd0);
    chk("busy1_idle",   64'(busy1),  64'd0);

    // All four valid from reset: grants 0,1,2,3,0,...
    do_reset();
    v1 = 4'b1111;
    a1 = {32'd3, 32'd2, 32'd1, 32'd0};
    b1 = {4{32'h100}};
    for (int k = 0; k < 8; k++) step(4'b0001 << (k % 4), 4'd0);
    v1 = 4'd0;
    drain(3);

    // Overflow on requester 2
    v1 = 4'b0100; a1[64 +: 32] = 32'hFFFF_FFFF; b1[64 +: 32] = 32'h2;
    step(4'b0100, 4'd0);
    v1 = 4'd0;
    step(4'd0, 4'd0);
    chk("ovf_sum_held",   64'(sum1),   64'h1);
    chk("ovf_carry_held", 64'(carry1), 64'd1);

    // Latency 3, requester 2 held valid: accepted every third cycle
    v3 = 4'b0100; b3[64 +: 32] = 32'h20;
    for (int k = 0; k < 9; k++) begin
      a3[64 +: 32] = 32'h1000 + 32'(k);
      step(4'd0, (k % 3 == 0) ? 4'b0100 : 4'b0000);
      chk("busy3_hold", 64'(busy3), 64'd1);
    end
    v3 = 4'd0;
    drain(5);

    // Reset one cycle after accepting requester 1: result must vanish
    v3 = 4'b0010; a3[32 +: 32] = 32'h7; b3[32 +: 32] = 32'h9;
    step(4'd0, 4'b0010);
    v3 = 4'd0;
    step(4'd0, 4'd0);
    do_reset();
    chk("busy3_after_rst", 64'(busy3), 64'd0);
    drain(5);
    v3 = 4'b0010;
    step(4'd0, 4'b0010);
    v3 = 4'd0;
    drain(4);

    // Requesters 0 and 3 continuously valid
    do_reset();
    v1 = 4'b1001;
    a1[31:0] = 32'h11; b1[31:0] = 32'h1;
    a1[96 +: 32] = 32'h33; b1[96 +: 32] = 32'h1;
    for (int k = 0; k < 6; k++) begin
`ifdef ADDER_SHARE_ARB_HOST_PRIO_EN
      step(4'b0001, 4'd0);
`else
      step((k % 2 == 0) ? 4'b0001 : 4'b1000, 4'd0);
`endif
    end
    v1 = 4'b1000;
    step(4'b1000, 4'd0);
    v1 = 4'd0;
    drain(3);

    chk("q1_empty", 64'(q1.size()), 64'd0);
    chk("q3_empty", 64'(q3.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
